// File: rtl/glb_skew_fifo_if.sv
`default_nettype none
// ============================================================================
// Module  : glb_skew_fifo_if
// Brief   : Handshake/data bundle between the data mover, the global-buffer
//           skew FIFO and the systolic-array row inputs.
// Revision: 1.0 - initial release
// ============================================================================
interface glb_skew_fifo_if #(
    parameter int DATA_WIDTH = 128,
    parameter int PE_SIZE    = 16,
    parameter int DEPTH      = 16
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic                  wren_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  rden_i;
    logic [DATA_WIDTH-1:0] sa_data_o;
    logic [PE_SIZE-1:0]    sa_valid_o;
    logic [c_CNT_W-1:0]    count_o;
    logic                  full_o;
    logic                  empty_o;
    logic                  overflow_o;
    logic                  underflow_o;

    modport master (
        output wren_i, wdata_i, rden_i,
        input  sa_data_o, sa_valid_o, count_o, full_o, empty_o,
               overflow_o, underflow_o
    );

    modport slave (
        input  wren_i, wdata_i, rden_i,
        output sa_data_o, sa_valid_o, count_o, full_o, empty_o,
               overflow_o, underflow_o
    );
endinterface
`default_nettype wire

// File: rtl/glb_skew_fifo.sv
`default_nettype none
// ============================================================================
// Module  : glb_skew_fifo
// Brief   : Global-buffer FIFO feeding a per-lane diagonal skew pipeline into
//           the systolic array rows. Skew enabled by GLB_SKEW_FIFO_SKEW_EN.
// Revision: 1.0 - initial release
// ============================================================================
module glb_skew_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int PE_SIZE    = 16,
    parameter int LANE_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic           clk,
    input  logic           rst,
    glb_skew_fifo_if.slave bus
);
    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_ADDR_W-1:0]   r_wr_ptr;
    logic [c_ADDR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_fire;
    logic                  w_wr_fire;

    logic [DATA_WIDTH-1:0] r_s0_data;
    logic                  r_s0_valid;

    logic [DATA_WIDTH-1:0] w_lane_data;
    logic [PE_SIZE-1:0]    w_lane_valid;
    logic [DATA_WIDTH-1:0] w_gated_data;

    // Flags come from the registered count so the pointers may wrap freely.
    assign w_full    = (r_count == c_CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_rd_fire = bus.rden_i & ~w_empty;
    assign w_wr_fire = bus.wren_i & (~w_full | w_rd_fire);

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_ptr] <= bus.wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            case ({w_wr_fire, w_rd_fire})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (bus.wren_i & ~w_wr_fire) begin
                r_overflow <= 1'b1;
            end
            if (bus.rden_i & w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Stage 0: common entry point for every lane; zeroed when nothing is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_data  <= '0;
        end else begin
            r_s0_valid <= w_rd_fire;
            r_s0_data  <= w_rd_fire ? r_mem[r_rd_ptr] : '0;
        end
    end

`ifdef GLB_SKEW_FIFO_SKEW_EN
    for (genvar k = 0; k < PE_SIZE; k++) begin : g_lane
        if (k == 0) begin : g_direct
            assign w_lane_valid[k]                           = r_s0_valid;
            assign w_lane_data[k*LANE_WIDTH +: LANE_WIDTH]   = r_s0_data[k*LANE_WIDTH +: LANE_WIDTH];
        end else begin : g_delay
            // Lane k carries its valid alongside the data through k registers.
            logic [LANE_WIDTH:0] r_pipe [k];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < k; j++) begin
                        r_pipe[j] <= '0;
                    end
                end else begin
                    r_pipe[0] <= {r_s0_valid, r_s0_data[k*LANE_WIDTH +: LANE_WIDTH]};
                    for (int j = 1; j < k; j++) begin
                        r_pipe[j] <= r_pipe[j-1];
                    end
                end
            end

            assign w_lane_valid[k]                         = r_pipe[k-1][LANE_WIDTH];
            assign w_lane_data[k*LANE_WIDTH +: LANE_WIDTH] = r_pipe[k-1][LANE_WIDTH-1:0];
        end
    end
`else
    assign w_lane_valid = {PE_SIZE{r_s0_valid}};
    assign w_lane_data  = r_s0_data;
`endif

    for (genvar k = 0; k < PE_SIZE; k++) begin : g_gate
        assign w_gated_data[k*LANE_WIDTH +: LANE_WIDTH] =
            w_lane_valid[k] ? w_lane_data[k*LANE_WIDTH +: LANE_WIDTH] : '0;
    end

    assign bus.sa_data_o   = w_gated_data;
    assign bus.sa_valid_o  = w_lane_valid;
    assign bus.count_o     = r_count;
    assign bus.full_o      = w_full;
    assign bus.empty_o     = w_empty;
    assign bus.overflow_o  = r_overflow;
    assign bus.underflow_o = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_glb_skew_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_glb_skew_fifo
// Brief   : Directed self-checking bench for glb_skew_fifo (both skew builds).
// Revision: 1.0 - initial release
// ============================================================================
module tb_glb_skew_fifo;
    localparam int DATA_WIDTH = 128;
    localparam int PE_SIZE    = 16;
    localparam int LANE_WIDTH = 8;
    localparam int DEPTH      = 16;
`ifdef GLB_SKEW_FIFO_SKEW_EN
    localparam int c_SKEW = 1;
`else
    localparam int c_SKEW = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    glb_skew_fifo_if #(.DATA_WIDTH(DATA_WIDTH), .PE_SIZE(PE_SIZE), .DEPTH(DEPTH)) bus ();

    glb_skew_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .PE_SIZE   (PE_SIZE),
        .LANE_WIDTH(LANE_WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.wren_i = 1'b0;
        bus.rden_i = 1'b0;
        bus.wdata_i = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic int lane_dly(input int k);
        return (c_SKEW != 0) ? k : 0;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rep(input int v);
        logic [DATA_WIDTH-1:0] w;
        for (int k = 0; k < PE_SIZE; k++) w[k*LANE_WIDTH +: LANE_WIDTH] = LANE_WIDTH'(v);
        return w;
    endfunction

    initial begin
        logic [DATA_WIDTH-1:0] word;
        logic [DATA_WIDTH-1:0] exp_d;
        logic [PE_SIZE-1:0]    exp_v;
        int                    r;

        bus.wren_i = 1'b0;
        bus.rden_i = 1'b0;
        bus.wdata_i = '0;
        #2;
        // reset state while rst is held
        chk("rst_count", bus.count_o, 0);
        chk("rst_empty", bus.empty_o, 1);
        chk("rst_full", bus.full_o, 0);
        chk("rst_ovf", bus.overflow_o, 0);
        chk("rst_udf", bus.underflow_o, 0);
        chk("rst_valid", bus.sa_valid_o, 0);
        chk("rst_data", bus.sa_data_o, 0);
        do_reset();

        // single word, lane k = k
        for (int k = 0; k < PE_SIZE; k++) word[k*LANE_WIDTH +: LANE_WIDTH] = LANE_WIDTH'(k);
        bus.wren_i = 1'b1;
        bus.wdata_i = word;
        tick();
        bus.wren_i = 1'b0;
        chk("single_count", bus.count_o, 1);
        chk("single_empty", bus.empty_o, 0);
        tick();
        bus.rden_i = 1'b1;
        tick();
        bus.rden_i = 1'b0;
        for (int j = 0; j <= PE_SIZE; j++) begin
            exp_v = '0;
            exp_d = '0;
            for (int k = 0; k < PE_SIZE; k++) begin
                if (j == lane_dly(k)) begin
                    exp_v[k] = 1'b1;
                    exp_d[k*LANE_WIDTH +: LANE_WIDTH] = LANE_WIDTH'(k);
                end
            end
            chk("single_valid", bus.sa_valid_o, exp_v);
            chk("single_data", bus.sa_data_o, exp_d);
            tick();
        end

        // fill to full, then write+read while full, then a lone overflowing write
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            bus.wren_i = 1'b1;
            bus.wdata_i = rep(i + 1);
            tick();
        end
        chk("fill_count", bus.count_o, 16);
        chk("fill_full", bus.full_o, 1);
        chk("fill_empty", bus.empty_o, 0);
        bus.wdata_i = rep(99);
        bus.rden_i = 1'b1;
        tick();
        bus.rden_i = 1'b0;
        chk("full_wr_rd_count", bus.count_o, 16);
        chk("full_wr_rd_ovf", bus.overflow_o, 0);
        chk("full_wr_rd_v0", bus.sa_valid_o[0], 1);
        chk("full_wr_rd_d0", bus.sa_data_o[LANE_WIDTH-1:0], 1);
        bus.wdata_i = rep(77);
        tick();
        bus.wren_i = 1'b0;
        chk("ovf_flag", bus.overflow_o, 1);
        chk("ovf_count", bus.count_o, 16);
        chk("ovf_full", bus.full_o, 1);

        // read on empty
        do_reset();
        bus.rden_i = 1'b1;
        tick();
        bus.rden_i = 1'b0;
        chk("udf_flag", bus.underflow_o, 1);
        chk("udf_valid", bus.sa_valid_o, 0);
        chk("udf_count", bus.count_o, 0);
        chk("udf_empty", bus.empty_o, 1);
        tick();
        chk("udf_valid2", bus.sa_valid_o, 0);

        // streaming 40 words, read one cycle behind write
        do_reset();
        for (int e = 0; e < 40 + PE_SIZE + 2; e++) begin
            bus.wren_i = (e < 40);
            bus.wdata_i = rep(e);
            bus.rden_i = (e >= 1 && e <= 40);
            tick();
            exp_v = '0;
            exp_d = '0;
            for (int k = 0; k < PE_SIZE; k++) begin
                r = e - lane_dly(k);
                if (r >= 1 && r <= 40) begin
                    exp_v[k] = 1'b1;
                    exp_d[k*LANE_WIDTH +: LANE_WIDTH] = LANE_WIDTH'(r - 1);
                end
            end
            chk("stream_valid", bus.sa_valid_o, exp_v);
            chk("stream_data", bus.sa_data_o, exp_d);
            chk("stream_count", bus.count_o, (e < 40) ? 1 : 0);
        end
        bus.wren_i = 1'b0;
        bus.rden_i = 1'b0;
        chk("stream_ovf", bus.overflow_o, 0);
        chk("stream_udf", bus.underflow_o, 0);

        // simultaneous write+read on empty: write only
        do_reset();
        bus.wren_i = 1'b1;
        bus.rden_i = 1'b1;
        bus.wdata_i = rep(5);
        tick();
        bus.wren_i = 1'b0;
        bus.rden_i = 1'b0;
        chk("wr_rd_empty_count", bus.count_o, 1);
        chk("wr_rd_empty_valid", bus.sa_valid_o, 0);
        tick();
        chk("wr_rd_empty_valid2", bus.sa_valid_o, 0);
        chk("wr_rd_empty_count2", bus.count_o, 1);

        // reset pulse with 5 stored and 3 in flight
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.wren_i = 1'b1;
            bus.wdata_i = rep(i + 1);
            tick();
        end
        bus.wren_i = 1'b0;
        bus.rden_i = 1'b1;
        tick();
        tick();
        tick();
        bus.rden_i = 1'b0;
        chk("mid_count", bus.count_o, 5);
        chk("mid_valid", bus.sa_valid_o, (c_SKEW != 0) ? 16'h0007 : 16'hFFFF);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus.sa_valid_o, 0);
        chk("mid_rst_data", bus.sa_data_o, 0);
        chk("mid_rst_count", bus.count_o, 0);
        chk("mid_rst_empty", bus.empty_o, 1);
        chk("mid_rst_full", bus.full_o, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_valid", bus.sa_valid_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
